// File: rtl/clock_12h_pkg.sv
// rtl/clock_12h_pkg.sv - shared field widths and limits for the 12-hour clock
package clock_12h_pkg;
  localparam int HOUR_W = 4;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [SEC_W-1:0]  SEC_MAX    = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX    = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX   = 4'd12;
  localparam logic [HOUR_W-1:0] HOUR_MIN   = 4'd1;
  localparam logic [HOUR_W-1:0] RESET_HOUR = 4'd12;

  // Hour after a carry; anything outside 1..12 recovers to 1.
  function automatic logic [HOUR_W-1:0] next_hour(input logic [HOUR_W-1:0] h);
    if (h == 4'd0 || h >= HOUR_MAX) return HOUR_MIN;
    return h + 4'd1;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides the system clock down to a one-second tick
module tick_prescaler #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_count;

  assign tick = (r_count >= LAST);

  always_ff @(posedge clk) begin
    if (rst)       r_count <= '0;
    else if (tick) r_count <= '0;
    else           r_count <= r_count + 1'b1;
  end
endmodule

// File: rtl/clock_12h.sv
// rtl/clock_12h.sv - free-running 12-hour hh:mm:ss counter with AM/PM flag
module clock_12h
  import clock_12h_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  minutes,
  output logic [SEC_W-1:0]  seconds,
  output logic              am_pm
);
  logic              w_tick;
  logic              w_sec_wrap;
  logic              w_min_wrap;
  logic              w_hour_carry;
  logic [HOUR_W-1:0] r_hours;
  logic [MIN_W-1:0]  r_minutes;
  logic [SEC_W-1:0]  r_seconds;
  logic              r_am_pm;

  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // Values above the maximum behave like the maximum so upsets self-heal.
  assign w_sec_wrap   = (r_seconds >= SEC_MAX);
  assign w_min_wrap   = (r_minutes >= MIN_MAX);
  assign w_hour_carry = w_tick && w_sec_wrap && w_min_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hours   <= RESET_HOUR;
      r_minutes <= '0;
      r_seconds <= '0;
      r_am_pm   <= 1'b0;
    end else if (w_tick) begin
      r_seconds <= w_sec_wrap ? '0 : r_seconds + 6'd1;
      if (w_sec_wrap) r_minutes <= w_min_wrap ? '0 : r_minutes + 6'd1;
      if (w_hour_carry) begin
        r_hours <= next_hour(r_hours);
        if (r_hours == HOUR_MAX - 4'd1) r_am_pm <= ~r_am_pm;
      end
    end
  end

  assign hours   = r_hours;
  assign minutes = r_minutes;
  assign seconds = r_seconds;
  assign am_pm   = r_am_pm;
endmodule

// File: tb/tb_clock_12h.sv
// tb/tb_clock_12h.sv - scoreboard bench for clock_12h at CLK_DIV 1 and 4
module tb_clock_12h;
  typedef struct packed {
    logic [3:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       ap;
  } time_t;

  localparam time_t T_RESET = '{h: 4'd12, m: 6'd0, s: 6'd0, ap: 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst4 = 1'b1;
  logic [3:0] hours, hours4;
  logic [5:0] minutes, minutes4, seconds, seconds4;
  logic       am_pm, am_pm4;

  int    total = 0;
  int    bad = 0;
  time_t m_cur;
  time_t exp_q[$];

  always #5 clk = ~clk;

  clock_12h #(.CLK_DIV(1)) u_dut (
    .clk(clk), .rst(rst), .hours(hours), .minutes(minutes), .seconds(seconds), .am_pm(am_pm)
  );

  clock_12h #(.CLK_DIV(4)) u_div4 (
    .clk(clk), .rst(rst4), .hours(hours4), .minutes(minutes4), .seconds(seconds4), .am_pm(am_pm4)
  );

  function automatic time_t model_tick(input time_t t);
    time_t n;
    logic  cs, cm;
    n  = t;
    cs = (t.s >= 6'd59);
    cm = cs && (t.m >= 6'd59);
    n.s = cs ? 6'd0 : 6'(t.s + 6'd1);
    if (cs) n.m = (t.m >= 6'd59) ? 6'd0 : 6'(t.m + 6'd1);
    if (cm) begin
      if (t.h == 4'd11) begin
        n.h  = 4'd12;
        n.ap = ~t.ap;
      end else if (t.h >= 4'd1 && t.h <= 4'd10) begin
        n.h = 4'(t.h + 4'd1);
      end else begin
        n.h = 4'd1;
      end
    end
    return n;
  endfunction

  task automatic run_edges(input int n, input string name);
    time_t e, got;
    for (int i = 0; i < n; i++) begin
      e = rst ? T_RESET : model_tick(m_cur);
      exp_q.push_back(e);
      m_cur = e;
      @(posedge clk);
      #1;
      got = '{h: hours, m: minutes, s: seconds, ap: am_pm};
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s edge %0d: got %0d:%0d:%0d ap=%0d, want %0d:%0d:%0d ap=%0d",
                 name, i, got.h, got.m, got.s, got.ap, e.h, e.m, e.s, e.ap);
      end
    end
  endtask

  task automatic hold_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_cur = T_RESET;
    run_edges(10, "reset_hold");
    rst = 1'b0;
    run_edges(60, "reset_release");
  endtask

  task automatic test_mid_reset();
    run_edges(100, "mid_run");
    rst = 1'b1;
    run_edges(2, "mid_reset");
    rst = 1'b0;
    run_edges(3, "mid_resume");
  endtask

  task automatic test_am_to_pm();
    force u_dut.r_hours = 4'd11;
    force u_dut.r_minutes = 6'd59;
    force u_dut.r_seconds = 6'd58;
    force u_dut.r_am_pm = 1'b0;
    hold_cycles(2);
    release u_dut.r_hours;
    release u_dut.r_minutes;
    release u_dut.r_seconds;
    release u_dut.r_am_pm;
    m_cur = '{h: 4'd11, m: 6'd59, s: 6'd58, ap: 1'b0};
    run_edges(5, "am_to_pm");
  endtask

  task automatic test_twelve_to_one();
    force u_dut.r_hours = 4'd12;
    force u_dut.r_minutes = 6'd59;
    force u_dut.r_seconds = 6'd58;
    force u_dut.r_am_pm = 1'b1;
    hold_cycles(2);
    release u_dut.r_hours;
    release u_dut.r_minutes;
    release u_dut.r_seconds;
    release u_dut.r_am_pm;
    m_cur = '{h: 4'd12, m: 6'd59, s: 6'd58, ap: 1'b1};
    run_edges(3, "twelve_to_one");
  endtask

  task automatic test_pm_to_am();
    force u_dut.r_hours = 4'd11;
    force u_dut.r_minutes = 6'd59;
    force u_dut.r_seconds = 6'd59;
    force u_dut.r_am_pm = 1'b1;
    hold_cycles(2);
    release u_dut.r_hours;
    release u_dut.r_minutes;
    release u_dut.r_seconds;
    release u_dut.r_am_pm;
    m_cur = '{h: 4'd11, m: 6'd59, s: 6'd59, ap: 1'b1};
    run_edges(2, "pm_to_am");
  endtask

  task automatic test_out_of_range();
    force u_dut.r_hours = 4'd14;
    force u_dut.r_minutes = 6'd59;
    force u_dut.r_seconds = 6'd62;
    force u_dut.r_am_pm = 1'b1;
    hold_cycles(2);
    release u_dut.r_hours;
    release u_dut.r_minutes;
    release u_dut.r_seconds;
    release u_dut.r_am_pm;
    m_cur = '{h: 4'd14, m: 6'd59, s: 6'd62, ap: 1'b1};
    run_edges(2, "out_of_range");
    // Out-of-range hour with no carry must hold.
    force u_dut.r_hours = 4'd0;
    force u_dut.r_seconds = 6'd10;
    hold_cycles(1);
    release u_dut.r_hours;
    release u_dut.r_seconds;
    m_cur = '{h: 4'd0, m: minutes, s: 6'd10, ap: 1'b1};
    run_edges(3, "hour_hold");
  endtask

  task automatic test_prescaler();
    time_t q4[$];
    time_t cur4, e, got;
    int    cnt;
    rst4 = 1'b0;
    cur4 = T_RESET;
    cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      if (cnt == 3) begin
        cur4 = model_tick(cur4);
        cnt = 0;
      end else begin
        cnt++;
      end
      q4.push_back(cur4);
      @(posedge clk);
      #1;
      got = '{h: hours4, m: minutes4, s: seconds4, ap: am_pm4};
      e = q4.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL prescaler edge %0d: got %0d:%0d:%0d ap=%0d, want %0d:%0d:%0d ap=%0d",
                 i, got.h, got.m, got.s, got.ap, e.h, e.m, e.s, e.ap);
      end
    end
    total++;
    if (seconds4 !== 6'd3) begin
      bad++;
      $display("FAIL prescaler_edge12: got seconds=%0d, want 3", seconds4);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_mid_reset();
    test_am_to_pm();
    test_twelve_to_one();
    test_pm_to_am();
    test_out_of_range();
    test_prescaler();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
